// File: rtl/mux4_sel_reg_if.sv
// Signal bundle for the four-way selector: packed data, select code, load
// enable, and the combinational and registered results.
interface mux4_sel_reg_if #(
  parameter int WIDTH = 1
);
  logic [4*WIDTH-1:0] in;
  logic [1:0]         sel;
  logic               en;
  logic [WIDTH-1:0]   out;
  logic [WIDTH-1:0]   out_q;
  logic [1:0]         sel_q;

  modport master (
    output in, sel, en,
    input  out, out_q, sel_q
  );

  modport slave (
    input  in, sel, en,
    output out, out_q, sel_q
  );
endinterface

// File: rtl/mux4_sel_reg.sv
// Four-input selector with a zero-latency output and an enable-gated
// registered copy of the selected data and select code.
module mux4_sel_reg #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux4_sel_reg_if.slave  bus
);

  logic [WIDTH-1:0] slice [4];
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_cap_q, sel_cap_d;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      assign slice[gi] = bus.in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Unknown select codes deliberately produce X rather than falling back to input 0.
  always_comb begin
    sel_data = 'x;
    case (bus.sel)
      2'b00:   sel_data = slice[0];
      2'b01:   sel_data = slice[1];
      2'b10:   sel_data = slice[2];
      2'b11:   sel_data = slice[3];
      default: sel_data = 'x;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    sel_cap_d = sel_cap_q;
    if (bus.en) begin
      data_d    = sel_data;
      sel_cap_d = bus.sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      sel_cap_q <= 2'b00;
    end else begin
      data_q    <= data_d;
      sel_cap_q <= sel_cap_d;
    end
  end

  assign bus.out   = sel_data;
  assign bus.out_q = data_q;
  assign bus.sel_q = sel_cap_q;

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Directed bench for mux4_sel_reg: one-bit baseline instance and an
// eight-bit instance sharing clock and reset.
module tb_mux4_sel_reg;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mux4_sel_reg_if #(.WIDTH(1)) nbus ();
  mux4_sel_reg_if #(.WIDTH(8)) wbus ();

  mux4_sel_reg #(.WIDTH(1)) u_narrow (.clk(clk), .rst(rst), .bus(nbus));
  mux4_sel_reg #(.WIDTH(8)) u_wide   (.clk(clk), .rst(rst), .bus(wbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst      = 1'b1;
    nbus.in  = 4'b1111;
    nbus.sel = 2'b10;
    nbus.en  = 1'b1;
    wbus.in  = 32'hFFFF_FFFF;
    wbus.sel = 2'b11;
    wbus.en  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (nbus.out_q !== 1'b0 || nbus.sel_q !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_narrow: out_q=%b sel_q=%b expected out_q=0 sel_q=00", nbus.out_q, nbus.sel_q);
    end else $display("reset_narrow: out_q=%b sel_q=%b ok", nbus.out_q, nbus.sel_q);
    vectors++;
    if (wbus.out_q !== 8'h00 || wbus.sel_q !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_wide: out_q=%h sel_q=%b expected out_q=00 sel_q=00", wbus.out_q, wbus.sel_q);
    end else $display("reset_wide: out_q=%h sel_q=%b ok", wbus.out_q, wbus.sel_q);
    vectors++;
    if (nbus.out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_comb: out=%b expected 1", nbus.out);
    end else $display("reset_comb: out=%b ok", nbus.out);
    @(negedge clk);
    nbus.en = 1'b0;
    wbus.en = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic sweep(input logic [3:0] pattern, input logic [3:0] expect_bits, input string name);
    nbus.in = pattern;
    for (int s = 0; s < 4; s++) begin
      nbus.sel = s[1:0];
      #10;
      vectors++;
      if (nbus.out !== expect_bits[s]) begin
        miscompares++;
        $display("FAIL %s sel=%0d: out=%b expected %b", name, s, nbus.out, expect_bits[s]);
      end else $display("%s sel=%0d: out=%b ok", name, s, nbus.out);
    end
  endtask

  task automatic test_comb_sweep();
    sweep(4'b1010, 4'b1010, "comb_sweep");
  endtask

  task automatic test_complement();
    sweep(4'b0101, 4'b0101, "complement");
  endtask

  task automatic test_capture_hold();
    @(negedge clk);
    nbus.in  = 4'b1010;
    nbus.sel = 2'b01;
    nbus.en  = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (nbus.out_q !== 1'b1 || nbus.sel_q !== 2'b01) begin
      miscompares++;
      $display("FAIL capture: out_q=%b sel_q=%b expected out_q=1 sel_q=01", nbus.out_q, nbus.sel_q);
    end else $display("capture: out_q=%b sel_q=%b ok", nbus.out_q, nbus.sel_q);
    @(negedge clk);
    nbus.sel = 2'b10;
    nbus.en  = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (nbus.out_q !== 1'b1 || nbus.sel_q !== 2'b01 || nbus.out !== 1'b0) begin
      miscompares++;
      $display("FAIL hold: out_q=%b sel_q=%b out=%b expected out_q=1 sel_q=01 out=0", nbus.out_q, nbus.sel_q, nbus.out);
    end else $display("hold: out_q=%b sel_q=%b out=%b ok", nbus.out_q, nbus.sel_q, nbus.out);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    nbus.sel = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (nbus.out_q !== 1'b0 || nbus.sel_q !== 2'b00 || nbus.out !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: out_q=%b sel_q=%b out=%b expected out_q=0 sel_q=00 out=1", nbus.out_q, nbus.sel_q, nbus.out);
    end else $display("async_reset: out_q=%b sel_q=%b out=%b ok", nbus.out_q, nbus.sel_q, nbus.out);
    nbus.en = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (nbus.out_q !== 1'b0 || nbus.sel_q !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_hold: out_q=%b sel_q=%b expected out_q=0 sel_q=00", nbus.out_q, nbus.sel_q);
    end else $display("reset_hold: out_q=%b sel_q=%b ok", nbus.out_q, nbus.sel_q);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (nbus.out_q !== 1'b1 || nbus.sel_q !== 2'b11) begin
      miscompares++;
      $display("FAIL release_capture: out_q=%b sel_q=%b expected out_q=1 sel_q=11", nbus.out_q, nbus.sel_q);
    end else $display("release_capture: out_q=%b sel_q=%b ok", nbus.out_q, nbus.sel_q);
    @(negedge clk);
    nbus.en = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'hAA;
    exp_tab[1] = 8'hBB;
    exp_tab[2] = 8'hCC;
    exp_tab[3] = 8'hDD;
    @(negedge clk);
    wbus.in = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int s = 0; s < 4; s++) begin
      wbus.sel = s[1:0];
      wbus.en  = 1'b1;
      #1;
      vectors++;
      if (wbus.out !== exp_tab[s]) begin
        miscompares++;
        $display("FAIL wide_comb sel=%0d: out=%h expected %h", s, wbus.out, exp_tab[s]);
      end else $display("wide_comb sel=%0d: out=%h ok", s, wbus.out);
      @(posedge clk);
      #1;
      vectors++;
      if (wbus.out_q !== exp_tab[s] || wbus.sel_q !== s[1:0]) begin
        miscompares++;
        $display("FAIL wide_reg sel=%0d: out_q=%h sel_q=%b expected out_q=%h sel_q=%b", s, wbus.out_q, wbus.sel_q, exp_tab[s], s[1:0]);
      end else $display("wide_reg sel=%0d: out_q=%h sel_q=%b ok", s, wbus.out_q, wbus.sel_q);
      @(negedge clk);
    end
    wbus.sel = 2'b01;
    wbus.en  = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (wbus.out_q !== 8'hDD || wbus.sel_q !== 2'b11 || wbus.out !== 8'hBB) begin
      miscompares++;
      $display("FAIL wide_hold: out_q=%h sel_q=%b out=%h expected out_q=dd sel_q=11 out=bb", wbus.out_q, wbus.sel_q, wbus.out);
    end else $display("wide_hold: out_q=%h sel_q=%b out=%h ok", wbus.out_q, wbus.sel_q, wbus.out);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_comb_sweep();
    test_complement();
    test_capture_hold();
    test_async_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_sel_reg.md
Name: mux4_sel_reg

Overview:
- Four-input, one-output selector, parameterised per-input data width.
- Provides a zero-latency combinational output and a registered copy of the selected data for timing-critical downstream logic.
- Serves as a generic datapath steering primitive between peer blocks.
- The one-bit-wide configuration is the baseline exercised by block-level tests.

Parameters:
- WIDTH, 1, bit width of each of the four data inputs and of each output.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous, active-high reset.
- in  input  4*WIDTH  packed data inputs; input k occupies bits [k*WIDTH +: WIDTH], so input 0 is the LSB slice.
- sel  input  2  select code; 2'b00 selects input 0 through 2'b11 selects input 3.
- en  input  1  load enable for the registered stage.
- out  output  WIDTH  combinational selected data.
- out_q  output  WIDTH  registered selected data.
- sel_q  output  2  select code captured alongside out_q.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Combinational path:
  - out = in[sel*WIDTH +: WIDTH] at all times, including during reset.
  - Zero latency; purely combinational from in and sel.
  - No latches; every sel code is decoded explicitly.
  - sel containing X/Z drives out to X in simulation. Do not silently default to input 0.
- Registered path:
  - When rst is asserted, out_q = 0 and sel_q = 2'b00 immediately, independent of clk.
  - While rst is high, outputs hold those values.
  - On a rising clk with rst low and en = 1: out_q <= current out value, sel_q <= sel.
  - On a rising clk with rst low and en = 0: out_q and sel_q hold.
  - Latency from in/sel to out_q is one clock when en = 1.
- Boundary conditions:
  - sel changing in the same cycle as en: the registered values reflect sel and in sampled at that edge.
  - rst asserted mid-operation clears out_q/sel_q asynchronously. The first capture after release occurs on the first rising clk with rst low and en = 1.
  - rst deasserted coincident with a clock edge: no capture on that edge is required.
- Width rules:
  - No arithmetic; data passes bit-exact.
  - WIDTH must be >= 1.
- All four slices are independent; no priority among inputs.

Test Plan:
- Combinational sweep, WIDTH=1, in=4'b1010, sel stepped 00, 01, 10, 11 with 10 ns per step:
  - required out = 0, 1, 0, 1 respectively.
  - out follows each sel change with no clock.
- Complement pattern, in=4'b0101, same sel sweep -> out = 1, 0, 1, 0.
- Registered capture, in=4'b1010, en=1, sel=01, one rising clk -> out_q=1, sel_q=01.
  - Then sel=10 with en=0, clocked -> out_q stays 1, sel_q stays 01, while out=0.
- Async reset: with out_q=1, assert rst between clock edges -> out_q=0 and sel_q=00 immediately.
  - out still equals the selected input.
  - Release rst, en=1, sel=11, one clk -> out_q=1.
- Wide configuration, WIDTH=8, in={8'hDD,8'hCC,8'hBB,8'hAA}:
  - sel=00 -> out=8'hAA; sel=01 -> 8'hBB; sel=10 -> 8'hCC; sel=11 -> 8'hDD.
  - The registered copy matches one clock later with en=1.
